rob_commit_ctrl: RTL
====================

// Module: rob_commit_ctrl
// PURPOSE
//  Sequences the ROB from the commit side. In RUN it retires up to COMMIT_WIDTH consecutive
//  finished, exception-free entries per cycle from the head, releasing old physical regs.
//  On an exception at the oldest unretired entry it walks the ROB tail->exception entry,
//  one entry per cycle, restoring the rename map and freeing new physical regs, then pulses
//  the ROB/pipeline flush. Sits between rob, rename map/free list and the CSR counters.
// PARAMETERS
//  COMMIT_WIDTH   4  retire lanes per cycle
//  ROB_ID_WIDTH   6  ROB index width (ROB depth = 2**ROB_ID_WIDTH)
//  ARCH_ID_WIDTH  5  architectural register index width
//  PHY_ID_WIDTH   7  physical register index width
// PORTS
//  clk               in   1                   clock
//  rst               in   1                   reset, synchronous, active-high
//  head_id           in   ROB_ID_WIDTH        ROB head index
//  head_valid        in   1                   ROB non-empty
//  retire_id         out  CW*ROB_ID_WIDTH     lane i = head_id+i (mod depth)
//  retire_id_valid   in   CW                  lane entry is in ROB range
//  retire_finish     in   CW                  lane entry executed
//  retire_exception  in   CW                  lane entry raised exception
//  retire_rd_valid   in   CW                  lane entry writes rd
//  retire_old_phy    in   CW*PHY_ID_WIDTH     lane entry old phy reg
//  retire_pop        out  CW                  pop mask to ROB (thermometer from lane 0)
//  free_valid        out  CW                  release free_phy[i] to free list
//  free_phy          out  CW*PHY_ID_WIDTH     phy reg released at retire
//  tail_id           in   ROB_ID_WIDTH        ROB youngest entry index
//  walk_id           out  ROB_ID_WIDTH        entry being undone (ROB flush read port)
//  walk_rd_valid     in   1                   walked entry writes rd
//  walk_rd           in   ARCH_ID_WIDTH       walked entry arch rd
//  walk_old_phy      in   PHY_ID_WIDTH        walked entry old phy reg
//  walk_new_phy      in   PHY_ID_WIDTH        walked entry new phy reg
//  restore_valid     out  1                   map[restore_rd] <= restore_phy; free walk_new_phy
//  restore_rd        out  ARCH_ID_WIDTH       arch reg restored
//  restore_phy       out  PHY_ID_WIDTH        old phy reg written back to map
//  restore_free_phy  out  PHY_ID_WIDTH        new phy reg returned to free list
//  rename_stall      out  1                   block rename allocation (WALK/FLUSH)
//  flush             out  1                   one-cycle flush to ROB and pipeline
//  flush_exc_id      out  ROB_ID_WIDTH        ROB index of excepting entry
//  retired_count     out  64                  total instructions retired
// BEHAVIOUR
//  FSM: RUN -> WALK -> FLUSH -> RUN. Reset: state RUN; all outputs 0, retired_count 0.
//  RUN (combinational, 0-cycle): lane i ok = head_valid & retire_id_valid[i] &
//   retire_finish[i] & ~retire_exception[i] & ok[i-1]; retire_pop = ok;
//   free_valid[i] = ok[i] & retire_rd_valid[i]; free_phy = retire_old_phy.
//  Exception: first non-ok lane k with valid & finish & exception -> lanes <k retire this cycle,
//   lane k NOT popped; register exc_id = head_id+k, cur = tail_id; next state WALK.
//  Unfinished lane stops retirement, no state change. head_valid=0 -> pop 0.
//  WALK: walk_id = cur; restore_valid = walk_rd_valid; one entry/cycle; exc entry itself
//   is undone. cur == exc_id -> FLUSH, else cur <= cur-1 (mod depth, wraps 0 -> depth-1).
//   retire_pop = 0, rename_stall = 1. N walked entries = N cycles.
//  FLUSH: flush = 1, flush_exc_id = exc_id, rename_stall = 1, for exactly one cycle; -> RUN.
//  retired_count += popcount(retire_pop) each cycle; 64-bit wrap; not cleared by flush.
//  rst in any state: next cycle RUN, walk aborted, no flush pulse.
//  Index arithmetic is ROB_ID_WIDTH wide, wrap-around intentional.
// STRUCTURE
//  Shared package: rob_commit_state_t enum {RUN, WALK, FLUSH}; ROB/PHY/ARCH id widths
//   from config.svh; rob_item_t field order owns the rd/old_phy/new_phy/finish/exception bits.
//  Sub-module: count_one (existing) for popcount of retire_pop; the rest stays flat.
// TESTING
//  4 finished clean entries head=62 -> pop=4'b1111, retire_id={62,63,0,1}, count +4.
//  Lane 2 unfinished, others finished -> pop=4'b0011, state stays RUN.
//  Lane 1 exception, head=5, tail=9 -> pop=4'b0001; walk_id 9,8,7,6 over 4 cycles; flush next
//   cycle, flush_exc_id=6.
//  Exception at head=0, tail=0 -> 1 WALK cycle (walk_id 0) then flush; rename_stall high 2 cycles.
//  Walk wrap: exc_id=62, tail=1 -> walk_id 1,0,63,62 then flush.
//  rst asserted mid-WALK -> next cycle RUN, flush never pulses, outputs 0, retired_count 0.

Source files
------------

// File: rtl/rob_commit_pkg.sv
// Shared types and default widths for the ROB commit controller.
package rob_commit_pkg;

  localparam int unsigned DefCommitWidth = 4;
  localparam int unsigned DefRobIdWidth  = 6;
  localparam int unsigned DefArchIdWidth = 5;
  localparam int unsigned DefPhyIdWidth  = 7;

  typedef enum logic [1:0] {
    StRun,
    StWalk,
    StFlush
  } rob_commit_state_t;

  // ROB entry layout; field order is shared with the ROB storage.
  typedef struct packed {
    logic                      rd_valid;
    logic [DefArchIdWidth-1:0] rd;
    logic [DefPhyIdWidth-1:0]  old_phy;
    logic [DefPhyIdWidth-1:0]  new_phy;
    logic                      finish;
    logic                      exception;
  } rob_item_t;

endpackage

// File: rtl/rob_commit_ctrl_count_one.sv
// Population count of a bit vector.
module count_one #(
  parameter int unsigned Width = 4,
  parameter int unsigned CntW  = $clog2(Width + 1)
) (
  input  logic [Width-1:0] bits_i,
  output logic [CntW-1:0]  count_o
);

  // Sum the set bits
  always_comb begin
    count_o = '0;
    for (int i = 0; i < int'(Width); i++) begin
      count_o = count_o + CntW'(bits_i[i]);
    end
  end

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB commit sequencer: in-order retire, exception rollback walk, flush pulse.
module rob_commit_ctrl
  import rob_commit_pkg::*;
#(
  parameter int unsigned CommitWidth = DefCommitWidth,
  parameter int unsigned RobIdWidth  = DefRobIdWidth,
  parameter int unsigned ArchIdWidth = DefArchIdWidth,
  parameter int unsigned PhyIdWidth  = DefPhyIdWidth
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [RobIdWidth-1:0]             head_id,
  input  logic                              head_valid,
  output logic [CommitWidth*RobIdWidth-1:0] retire_id,
  input  logic [CommitWidth-1:0]            retire_id_valid,
  input  logic [CommitWidth-1:0]            retire_finish,
  input  logic [CommitWidth-1:0]            retire_exception,
  input  logic [CommitWidth-1:0]            retire_rd_valid,
  input  logic [CommitWidth*PhyIdWidth-1:0] retire_old_phy,
  output logic [CommitWidth-1:0]            retire_pop,
  output logic [CommitWidth-1:0]            free_valid,
  output logic [CommitWidth*PhyIdWidth-1:0] free_phy,
  input  logic [RobIdWidth-1:0]             tail_id,
  output logic [RobIdWidth-1:0]             walk_id,
  input  logic                              walk_rd_valid,
  input  logic [ArchIdWidth-1:0]            walk_rd,
  input  logic [PhyIdWidth-1:0]             walk_old_phy,
  input  logic [PhyIdWidth-1:0]             walk_new_phy,
  output logic                              restore_valid,
  output logic [ArchIdWidth-1:0]            restore_rd,
  output logic [PhyIdWidth-1:0]             restore_phy,
  output logic [PhyIdWidth-1:0]             restore_free_phy,
  output logic                              rename_stall,
  output logic                              flush,
  output logic [RobIdWidth-1:0]             flush_exc_id,
  output logic [63:0]                       retired_count
);

  localparam int unsigned CntW = $clog2(CommitWidth + 1);

  rob_commit_state_t       state_q, state_d;
  logic [RobIdWidth-1:0]   exc_id_q, exc_id_d;
  logic [RobIdWidth-1:0]   cur_q, cur_d;
  logic [63:0]             count_q, count_d;
  logic [CommitWidth-1:0]  lane_ok;
  logic                    exc_hit;
  logic [RobIdWidth-1:0]   exc_lane_id;
  logic [CntW-1:0]         pop_count;

  // Lane i looks at head_id + i, wrapping modulo ROB depth
  always_comb begin
    retire_id = '0;
    for (int i = 0; i < int'(CommitWidth); i++) begin
      retire_id[i*RobIdWidth +: RobIdWidth] = head_id + RobIdWidth'(i);
    end
  end

  // Thermometer retire chain; the first broken lane is checked for an exception
  always_comb begin
    logic prev;
    lane_ok     = '0;
    exc_hit     = 1'b0;
    exc_lane_id = head_id;
    prev        = head_valid & ~rst;
    for (int i = 0; i < int'(CommitWidth); i++) begin
      lane_ok[i] = prev & retire_id_valid[i] & retire_finish[i] & ~retire_exception[i];
      // prev drops after the first non-ok lane, so at most one lane can match here
      if (prev && !lane_ok[i] && retire_id_valid[i] && retire_finish[i] &&
          retire_exception[i]) begin
        exc_hit     = 1'b1;
        exc_lane_id = head_id + RobIdWidth'(i);
      end
      prev = lane_ok[i];
    end
  end

  // FSM next state and outputs
  always_comb begin
    state_d          = state_q;
    exc_id_d         = exc_id_q;
    cur_d            = cur_q;
    retire_pop       = '0;
    walk_id          = '0;
    restore_valid    = 1'b0;
    restore_rd       = '0;
    restore_phy      = '0;
    restore_free_phy = '0;
    rename_stall     = 1'b0;
    flush            = 1'b0;
    flush_exc_id     = '0;
    case (state_q)
      StRun: begin
        retire_pop = lane_ok;
        if (exc_hit) begin
          exc_id_d = exc_lane_id;
          cur_d    = tail_id;
          state_d  = StWalk;
        end
      end
      StWalk: begin
        rename_stall     = 1'b1;
        walk_id          = cur_q;
        restore_valid    = walk_rd_valid;
        restore_rd       = walk_rd;
        restore_phy      = walk_old_phy;
        restore_free_phy = walk_new_phy;
        // The excepting entry itself is undone before flushing
        if (cur_q == exc_id_q) begin
          state_d = StFlush;
        end else begin
          cur_d = cur_q - RobIdWidth'(1);
        end
      end
      StFlush: begin
        flush        = 1'b1;
        flush_exc_id = exc_id_q;
        rename_stall = 1'b1;
        state_d      = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  // Old physical regs of retiring writers go back to the free list
  always_comb begin
    free_valid = retire_pop & retire_rd_valid;
    free_phy   = retire_old_phy;
    count_d    = count_q + 64'(pop_count);
  end

  count_one #(
    .Width (CommitWidth),
    .CntW  (CntW)
  ) u_count_one (
    .bits_i  (retire_pop),
    .count_o (pop_count)
  );

  assign retired_count = count_q;

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StRun;
      exc_id_q <= '0;
      cur_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      exc_id_q <= exc_id_d;
      cur_q    <= cur_d;
      count_q  <= count_d;
    end
  end

endmodule
